y_out_serializer: RTL and testbench



---
 rtl/y_out_serializer.sv | 106 ++++++++++
 tb/tb_y_out_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/y_out_serializer.sv
// Result-word serializer: captures four REG_W-bit words in one cycle and streams them
// out BYTE_W bits at a time, round-robin across the words, MSB byte first.
module y_out_serializer #(
  parameter  int BYTE_W    = 8,
  parameter  int REG_W     = 64,
  localparam int NUM_BYTES = 4 * REG_W / BYTE_W,
  localparam int CNT_W     = $clog2(NUM_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [REG_W-1:0]  Y_in1,
  input  logic [REG_W-1:0]  Y_in2,
  input  logic [REG_W-1:0]  Y_in3,
  input  logic [REG_W-1:0]  Y_in4,
  output logic              load_ack,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] Y_out,
  output logic              busy,
  output logic              ydrain_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REG_W-1:0]   r_s_reg [4];
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_lane;
  logic               r_done;
  logic               w_capture;
  logic               w_hs;
  logic               w_last;
  logic [BYTE_W-1:0]  w_top;

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  assign w_top = r_s_reg[r_lane][REG_W-1 -: BYTE_W];

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_hs        = 1'b0;
    w_last      = 1'b0;
    load_ack    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    Y_out       = '0;
    case (r_state)
      ST_IDLE: begin
        if (load_en) begin
          w_capture   = 1'b1;
          load_ack    = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        Y_out     = w_top;
        w_hs      = out_ready;
        w_last    = (r_cnt == CNT_W'(NUM_BYTES - 1));
        if (w_hs && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the four word registers are reset too, so Y_out and any abort leave no stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_s_reg[i] <= '0;
      r_cnt  <= '0;
      r_lane <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_hs && w_last;
      if (w_capture) begin
        r_s_reg[0] <= Y_in1;
        r_s_reg[1] <= Y_in2;
        r_s_reg[2] <= Y_in3;
        r_s_reg[3] <= Y_in4;
        r_cnt      <= '0;
        r_lane     <= '0;
      end else if (w_hs) begin
        // Consumed byte leaves the top; zeros enter at the bottom.
        r_s_reg[r_lane] <= {r_s_reg[r_lane][REG_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
        r_lane          <= r_lane + 2'd1;
        r_cnt           <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign ydrain_done = r_done;

endmodule

// File: tb/tb_y_out_serializer.sv
// Scoreboard bench for y_out_serializer: the driver queues expected bytes, and a
// negedge monitor pops and compares one byte on every handshake.
module tb_y_out_serializer;

  localparam int NB = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [63:0] y_in1 = '0, y_in2 = '0, y_in3 = '0, y_in4 = '0;
  logic        load_ack;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [7:0]  Y_out;
  logic        busy;
  logic        ydrain_done;

  y_out_serializer dut (
    .clk(clk), .rst(rst), .load_en(load_en),
    .Y_in1(y_in1), .Y_in2(y_in2), .Y_in3(y_in3), .Y_in4(y_in4),
    .load_ack(load_ack), .out_ready(out_ready), .out_valid(out_valid),
    .Y_out(Y_out), .busy(busy), .ydrain_done(ydrain_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  sb_q[$];
  int          hs_cnt = 0;
  bit          exp_done = 1'b0;
  bit          prev_hold = 1'b0;
  logic [7:0]  prev_byte = '0;
  logic [63:0] x_reg [4];
  int          x_lane = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: byte k comes from word k%4, slot k/4 counted from the MSB.
  task automatic push_words(input logic [63:0] w1, w2, w3, w4);
    logic [63:0] wv [4];
    wv[0] = w1; wv[1] = w2; wv[2] = w3; wv[3] = w4;
    for (int k = 0; k < NB; k++)
      sb_q.push_back(wv[k % 4][63 - 8 * (k / 4) -: 8]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the capture edge.
  task automatic load(input logic [63:0] w1, w2, w3, w4, input bit exp_ack);
    y_in1 = w1; y_in2 = w2; y_in3 = w3; y_in4 = w4;
    load_en = 1'b1;
    #1;
    check("load_ack", load_ack, exp_ack);
    if (exp_ack) begin
      push_words(w1, w2, w3, w4);
      for (int i = 0; i < 4; i++) x_reg[i] = '0;
      x_lane = 0;
    end
    tick();
    load_en = 1'b0;
    y_in1 = '0; y_in2 = '0; y_in3 = '0; y_in4 = '0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      cyc++;
      if (ydrain_done) begin
        got = 1'b1;
        break;
      end
    end
    check("ydrain_done_seen", got, 1'b1);
  endtask

  always @(negedge clk) begin
    check("ydrain_done", ydrain_done, exp_done);
    if (ydrain_done) begin
      check("hs_count", hs_cnt, NB);
      hs_cnt = 0;
    end
    exp_done = 1'b0;
    if (!out_valid) check("idle_y_out", Y_out, 8'h00);
    if (prev_hold && out_valid) check("y_stable", Y_out, prev_byte);
    prev_hold = out_valid && !out_ready;
    prev_byte = Y_out;
    if (out_valid && out_ready) begin
      check("sb_nonempty", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) check("y_out", Y_out, sb_q.pop_front());
      x_reg[x_lane] = {x_reg[x_lane][55:0], Y_out};
      x_lane = (x_lane + 1) % 4;
      hs_cnt++;
      if (hs_cnt == NB) exp_done = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] T_W1 = 64'h0011223344556677;
  localparam logic [63:0] T_W2 = 64'h8899AABBCCDDEEFF;
  localparam logic [63:0] T_W3 = 64'h0102030405060708;
  localparam logic [63:0] T_W4 = 64'hF0E0D0C0B0A09080;
  localparam logic [63:0] A_W1 = 64'h1122334455667788;
  localparam logic [63:0] A_W2 = 64'h99AABBCCDDEEFF00;
  localparam logic [63:0] A_W3 = 64'h2030405060708090;
  localparam logic [63:0] A_W4 = 64'hC1C2C3C4C5C6C7C8;
  localparam logic [63:0] AA   = 64'hA5A5A5A5A5A5A5A5;

  initial begin
    int cyc;
    logic [63:0] rw [4];

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_y_out", Y_out, 8'h00);
    check("rst_load_ack", load_ack, 1'b0);
    check("rst_ydrain_done", ydrain_done, 1'b0);
    #20;
    @(posedge clk);
    #3;
    rst = 1'b1;
    tick();

    // Test 1: asynchronous reset after 10 bytes aborts the transfer
    load(A_W1, A_W2, A_W3, A_W4, 1'b1);
    check("t1_first_byte", Y_out, 8'h11);
    repeat (10) tick();
    #2;
    sb_q.delete();
    hs_cnt = 0;
    exp_done = 1'b0;
    prev_hold = 1'b0;
    rst = 1'b0;
    #1;
    check("t1_abort_out_valid", out_valid, 1'b0);
    check("t1_abort_busy", busy, 1'b0);
    check("t1_abort_y_out", Y_out, 8'h00);
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (5) tick();
    load(A_W1, A_W2, A_W3, A_W4, 1'b1);
    check("t1_restart_byte", Y_out, 8'h11);
    check("t1_restart_valid", out_valid, 1'b1);
    wait_done(200, cyc);

    // Test 2: full-rate transfer of the reference words
    tick();
    load(T_W1, T_W2, T_W3, T_W4, 1'b1);
    check("t2_first_byte", Y_out, 8'h00);
    check("t2_busy", busy, 1'b1);
    tick();
    check("t2_second_byte", Y_out, 8'h88);
    wait_done(200, cyc);
    check("t2_cycles", cyc + 1, NB);
    check("t2_idle_after", busy, 1'b0);

    // Test 3: same data under random backpressure
    tick();
    load(T_W1, T_W2, T_W3, T_W4, 1'b1);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        if (ydrain_done) begin
          got = 1'b1;
          break;
        end
      end
      check("t3_done_seen", got, 1'b1);
    end
    out_ready = 1'b1;
    check("t3_sb_drained", sb_q.size(), 0);

    // Test 4: load_en during byte 5 is ignored
    tick();
    load(T_W1, T_W2, T_W3, T_W4, 1'b1);
    repeat (4) tick();
    check("t4_byte5", Y_out, 8'h11);
    load(64'hDEADBEEFDEADBEEF, 64'hDEADBEEFDEADBEEF,
         64'hDEADBEEFDEADBEEF, 64'hDEADBEEFDEADBEEF, 1'b0);
    wait_done(200, cyc);

    // Test 5: back-to-back load accepted in the ydrain_done cycle
    check("t5_gap_idle", out_valid, 1'b0);
    load(AA, AA, AA, AA, 1'b1);
    check("t5_next_valid", out_valid, 1'b1);
    check("t5_next_byte", Y_out, 8'hA5);
    wait_done(200, cyc);

    // Test 6: loopback into a round-robin shift-left byte loader
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 4; i++) rw[i] = {$urandom, $urandom};
      tick();
      load(rw[0], rw[1], rw[2], rw[3], 1'b1);
      wait_done(200, cyc);
      for (int i = 0; i < 4; i++) check($sformatf("t6_loop%0d_w%0d", n, i), x_reg[i], rw[i]);
    end

    repeat (3) tick();
    check("final_sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
